// File: rtl/rst_stream_pkg.sv
// Shared definitions for the counted-offset link: defaults and the
// encode/decode pair used by both ends of the stream.
package rst_stream_pkg;

    localparam int DW_DEF = 4;
    localparam int CW_DEF = 3;

    // Callers truncate the result to their data width, which gives the mod-2^DW wrap.
    function automatic logic [31:0] decode(input logic [31:0] data, input logic [31:0] count);
        return data - count;
    endfunction

    function automatic logic [31:0] encode(input logic [31:0] payload, input logic [31:0] count);
        return payload + count;
    endfunction

endpackage

// File: rtl/rst_sync_fifo.sv
// Synchronous first-word fall-through FIFO. Occupancy is tracked with a
// separate counter so that full/empty never depend on pointer equality.
module rst_sync_fifo #(
    parameter int DW    = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DW-1:0]              wdata,
    output logic                       full,
    input  logic                       pop,
    output logic [DW-1:0]              rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     fill
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    assign full  = (fill == FW'(DEPTH));
    assign empty = (fill == '0);
    // Forcing zero while empty gives the required post-reset data value.
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst_n && push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/rst_stream_decoder.sv
// Receive side of the counted-offset link: strips the beat index from
// each beat and buffers payloads for a valid/ready consumer.
module rst_stream_decoder
    import rst_stream_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int CW    = CW_DEF,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_i,
    input  logic [DW-1:0]              data_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [DW-1:0]              data_o,
    output logic [$clog2(DEPTH):0]     fill_o,
    output logic                       overflow_o
);
    logic [CW-1:0] count;
    logic [DW-1:0] dec;
    logic          full, empty, push, pop;

    assign dec     = DW'(decode(32'(data_i), 32'(count)));
    assign valid_o = !empty;
    assign pop     = valid_o & ready_i;
    // A full FIFO can still take a beat when the head leaves in the same cycle.
    assign push    = valid_i & (!full | pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            // Count every beat, stored or dropped, to stay aligned with the sender.
            if (valid_i) count <= count + 1'b1;
            if (valid_i && full && !pop) overflow_o <= 1'b1;
        end
    end

    rst_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (dec),
        .full  (full),
        .pop   (pop),
        .rdata (data_o),
        .empty (empty),
        .fill  (fill_o)
    );

endmodule

// File: tb/tb_rst_stream_decoder.sv
// Scoreboard bench for rst_stream_decoder: expected payloads are queued as
// beats are driven and compared while they sit at the FIFO head.
module tb_rst_stream_decoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_i = 1'b0;
    logic [3:0] data_i = '0;
    logic       valid_o;
    logic       ready_i = 1'b0;
    logic [3:0] data_o;
    logic [2:0] fill_o;
    logic       overflow_o;

    int errs = 0;
    int checks = 0;
    int q[$];
    int cnt = 0;
    bit ovf = 1'b0;

    rst_stream_decoder #(.DW(4), .CW(3), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .fill_o     (fill_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called just after a negedge: check outputs against the model, drive
    // this cycle's inputs, advance the model, then move to the next negedge.
    task automatic cycle(input bit v, input int d, input bit r);
        bit pop, full;
        valid_i = v;
        data_i  = 4'(d);
        ready_i = r;
        chk("valid_o", int'(valid_o), int'(q.size() != 0));
        if (q.size() != 0) chk("data_o", int'(data_o), q[0]);
        chk("fill_o", int'(fill_o), q.size());
        chk("overflow_o", int'(overflow_o), int'(ovf));
        pop  = (q.size() != 0) && r;
        full = (q.size() == 4);
        if (pop) void'(q.pop_front());
        if (v) begin
            if (!full || pop) q.push_back(((d % 16) - cnt + 16) % 16);
            else ovf = 1'b1;
            cnt = (cnt + 1) % 8;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input bit v, input bit r);
        rst_n   = 1'b0;
        valid_i = v;
        data_i  = 4'd7;
        ready_i = r;
        @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        valid_i = 1'b0;
        q.delete();
        cnt = 0;
        ovf = 1'b0;
        chk("rst_valid_o", int'(valid_o), 0);
        chk("rst_data_o", int'(data_o), 0);
        chk("rst_fill_o", int'(fill_o), 0);
        chk("rst_overflow_o", int'(overflow_o), 0);
    endtask

    initial begin
        @(negedge clk);
        do_reset(1'b1, 1'b1);

        // T1 basic
        cycle(1, 3, 1); cycle(1, 5, 1); cycle(1, 7, 1);
        chk("t1_fill_le1", int'(fill_o <= 3'd1), 1);
        chk("t1_head", int'(data_o), 5);
        cycle(0, 0, 1); cycle(0, 0, 1);

        // T2 wrap
        do_reset(1'b0, 1'b0);
        for (int k = 0; k < 10; k++) cycle(1, k % 8, 1);
        repeat (2) cycle(0, 0, 1);

        // T3 modular subtract
        do_reset(1'b0, 1'b0);
        cycle(1, 0, 0); cycle(1, 1, 0); cycle(1, 2, 0); cycle(1, 1, 0);
        repeat (3) cycle(0, 0, 1);
        chk("t3_fourth", int'(data_o), 14);
        cycle(0, 0, 1);

        // T4 overflow
        do_reset(1'b0, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1, k, 0);
        chk("t4_fill", int'(fill_o), 4);
        chk("t4_ovf", int'(overflow_o), 1);
        repeat (5) cycle(0, 0, 1);
        chk("t4_drained", int'(valid_o), 0);
        cycle(1, 5, 1);
        chk("t4_after", int'(data_o), 0);
        cycle(0, 0, 1);

        // T5 full + simultaneous pop/push
        do_reset(1'b0, 1'b0);
        cycle(1, 1, 0); cycle(1, 3, 0); cycle(1, 5, 0); cycle(1, 7, 0);
        cycle(1, 12, 1);
        chk("t5_fill", int'(fill_o), 4);
        chk("t5_ovf", int'(overflow_o), 0);
        chk("t5_head", int'(data_o), 2);
        repeat (5) cycle(0, 0, 1);

        // T6 reset mid-operation
        do_reset(1'b0, 1'b0);
        cycle(1, 2, 0); cycle(1, 2, 1); cycle(1, 2, 1); cycle(1, 2, 0); cycle(1, 2, 0);
        chk("t6_fill", int'(fill_o), 3);
        do_reset(1'b1, 1'b1);
        cycle(1, 9, 1);
        chk("t6_after", int'(data_o), 9);
        cycle(0, 0, 1);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else cycle(1'($urandom_range(0, 2) != 0), int'($urandom_range(0, 15)),
                       1'($urandom_range(0, 3) == 0));
        end
        repeat (6) cycle(0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
